seq_add64_ctrl: RTL and testbench
=================================

# seq_add64_ctrl

- Sequencing controller that performs a 64-bit add or subtract by time-multiplexing one 4-bit ripple-carry slice over 16 consecutive cycles.
- Latches operands on a start handshake and walks the nibbles LSB-first, carrying between cycles in a register.
- Reports the result with a one-cycle done pulse.
- Sits beside the combinational 64-bit adder variants as the area-minimal, multi-cycle alternative.

## Interface
- WIDTH, 64, operand/result width; must be a multiple of SLICE
- SLICE, 4, slice width in bits; step count N = WIDTH/SLICE = 16
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; accepted only when busy=0
- sub  input  1  0: A+B+cin; 1: A−B (A + ~B + 1, cin ignored)
- a  input  WIDTH  operand A, sampled on accept
- b  input  WIDTH  operand B, sampled on accept
- cin  input  1  carry-in for add, sampled on accept
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result, held until the next accept
- cout  output  1  carry out of bit WIDTH−1; for sub, 1 = no borrow
- overflow  output  1  two's-complement overflow of the operation

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - start=1 → latch a, b^{WIDTH{sub}}, carry = sub ? 1 : cin, sub_q, idx=0 → RUN.
- RUN, each cycle:
  - slice computes a_q[idx*SLICE+:SLICE] + b_q[same] + carry.
  - Slice sum written to sum[idx*SLICE+:SLICE]; carry ← slice cout; idx++.
  - On idx=N−1 → DONE.
- DONE
  - done=1 for exactly this cycle.
  - cout ← final carry.
  - overflow = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]), where b_q is the inverted operand for sub.
  - Next state IDLE, unless start=1 in DONE, which is accepted immediately → RUN. Back-to-back operations are allowed.
- busy = (state != IDLE) && !(state == DONE). busy is 0 in DONE so that a new start can be accepted.
- start while busy=1 is ignored; no queueing, no error.
- Operand inputs are don't-care except in the accept cycle.
- sum, cout and overflow are stable from DONE until the next accept. During RUN, sum is partially updated and not valid; only the done pulse qualifies it.
- idx width = clog2(N); no wrap beyond N−1.
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, overflow 0, carry 0, idx 0.
- Reset asserted mid-RUN aborts the operation: no done pulse, and all outputs return to their reset values asynchronously.

## Timing
- Accept at rising edge T (start=1, busy=0).
- busy=1 from T until edge T+N.
- done=1 in the cycle between edges T+N and T+N+1. Latency is N+1 edges from accept to done falling, N edges to done rising.
- Throughput: one operation per N+1 cycles with a start held high, because start is re-accepted in DONE.
- The slice is purely combinational. Critical path: one SLICE-bit ripple plus the register setup.

## Structure
- Shared package seq_add_pkg:
  - state enum {IDLE, RUN, DONE}
  - constants WIDTH_DEF=64, SLICE_DEF=4
  - function steps(WIDTH, SLICE)
- Sub-module add_slice:
  - parameterised SLICE-bit ripple carry built from single-bit full-adder cells.
  - ports a, b, c_in, sum, c_out.
- Exactly one add_slice instance. The controller owns the FSM, the operand/carry registers and the result register.

## Test plan
- Reset check
  - Stimulus: assert rst mid-RUN at step 7 of an add.
  - Required: busy, done, sum, cout and overflow go to 0 immediately. No done pulse follows. A new start after release completes normally.
- Basic add
  - Stimulus: a=0x0000_0000_0000_0001, b=0x0000_0000_0000_0002, cin=1, sub=0.
  - Required: done exactly 16 edges after accept; sum=0x4, cout=0, overflow=0.
- Full carry ripple
  - Stimulus: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0.
  - Required: sum=0, cout=1, overflow=0.
- Signed overflow
  - Stimulus: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, add.
  - Required: sum=0x8000_0000_0000_0000, cout=0, overflow=1.
- Subtract
  - Stimulus: a=5, b=7, sub=1.
  - Required: sum=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), overflow=0.
  - Stimulus: a=0x8000_0000_0000_0000, b=1, sub=1.
  - Required: overflow=1, cout=1.
- Handshake
  - Stimulus: start pulses during RUN with different operands.
  - Required: they are ignored and the result matches the original operands.
  - Stimulus: start held high continuously.
  - Required: done pulses every 17 cycles, and each sum matches the operands sampled at its accept.

Source files
------------

// File: rtl/seq_add_pkg.sv
// Shared types and constants for the sequential slice-based adder.
// Operand width must be an exact multiple of the slice width.
package seq_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 64;
  localparam int SLICE_DEF = 4;

  function automatic int steps(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/add_slice.sv
// SLICE-bit ripple-carry adder built from single-bit full-adder cells.
// Purely combinational; sets the critical path of the sequential adder.
module add_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] sum,
  output logic             c_out
);

  logic [SLICE:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[SLICE];

endmodule

// File: rtl/seq_add64_ctrl.sv
// Multi-cycle WIDTH-bit add/sub: one SLICE-bit slice walked LSB-first over N cycles.
// Done pulses N edges after accept; a start in the DONE cycle is accepted back-to-back.
module seq_add64_ctrl
  import seq_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N      = steps(WIDTH, SLICE);
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int BASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [BASE_W-1:0] base;
  logic [SLICE-1:0]  a_slice, b_slice, s_slice;
  logic              c_slice;
  logic              accept;

  assign base    = BASE_W'(int'(idx_q) * SLICE);
  assign a_slice = a_q[base +: SLICE];
  assign b_slice = b_q[base +: SLICE];

  add_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a     (a_slice),
    .b     (b_slice),
    .c_in  (carry_q),
    .sum   (s_slice),
    .c_out (c_slice)
  );

  // DONE is not busy, so a held start restarts without an idle cycle.
  assign accept = start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        sum_d[base +: SLICE] = s_slice;
        carry_d              = c_slice;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
          cout_d  = c_slice;
          // b_q already holds the inverted operand for subtract.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_slice[SLICE-1] != a_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d     = a;
      b_d     = b ^ {WIDTH{sub}};
      carry_d = sub ? 1'b1 : cin;
      idx_d   = '0;
      state_d = RUN;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_add64_ctrl.sv
// Bench for seq_add64_ctrl: directed vectors with literal expectations plus an
// arithmetic reference model compared against the outputs on every cycle.
module tb_seq_add64_ctrl;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout, overflow;
  logic [63:0] sum;

  int checks = 0;
  int failures = 0;

  seq_add64_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: k counts edges since accept (0 = idle, N+1 = done cycle).
  int          m_k = 0;
  logic [63:0] m_a, m_b;
  logic        m_cin, m_sub;
  logic [63:0] e_sum = '0;
  logic        e_cout = 1'b0;
  logic        e_ovf = 1'b0;
  logic        m_valid = 1'b1;

  always @(posedge clk or posedge rst) begin
    logic [64:0]        t;
    logic signed [65:0] s;
    if (rst) begin
      m_k = 0; e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0; m_valid = 1'b1;
    end else if ((m_k == 0 || m_k == N + 1) && start) begin
      m_a = a; m_b = b; m_cin = cin; m_sub = sub; m_k = 1; m_valid = 1'b0;
    end else if (m_k == N) begin
      if (m_sub) begin
        t = {1'b0, m_a} + {1'b0, ~m_b} + 65'd1;
        s = $signed({{2{m_a[63]}}, m_a}) - $signed({{2{m_b[63]}}, m_b});
      end else begin
        t = {1'b0, m_a} + {1'b0, m_b} + {64'd0, m_cin};
        s = $signed({{2{m_a[63]}}, m_a}) + $signed({{2{m_b[63]}}, m_b}) + $signed({65'd0, m_cin});
      end
      e_sum   = t[63:0];
      e_cout  = t[64];
      e_ovf   = !(s[65:63] == 3'b000 || s[65:63] == 3'b111);
      m_k     = N + 1;
      m_valid = 1'b1;
    end else if (m_k == N + 1) begin
      m_k = 0;
    end else if (m_k > 0) begin
      m_k++;
    end
  end

  always @(negedge clk) begin
    chk("busy", {63'd0, busy}, {63'd0, (m_k >= 1 && m_k <= N)});
    chk("done", {63'd0, done}, {63'd0, (m_k == N + 1)});
    if (m_valid) begin
      chk("sum", sum, e_sum);
      chk("cout", {63'd0, cout}, {63'd0, e_cout});
      chk("overflow", {63'd0, overflow}, {63'd0, e_ovf});
    end
  end

  task automatic run_op(input logic [63:0] va, input logic [63:0] vb, input logic vcin,
                        input logic vsub, input logic noise, input logic [63:0] xs,
                        input logic xc, input logic xo);
    int  n;
    bit  got;
    @(negedge clk);
    a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
    n = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0; a = ~va; b = va ^ vb; cin = ~vcin; sub = ~vsub;
      end
      if (noise && n == 5) begin
        start = 1'b1; a = 64'h0123_4567_89AB_CDEF; b = 64'hFEDC_BA98_7654_3210;
      end
      if (noise && n == 6) start = 1'b0;
      if (done) got = 1;
    end
    chk("latency", 64'(n - 1), 64'(N));
    chk("lit_sum", sum, xs);
    chk("lit_cout", {63'd0, cout}, {63'd0, xc});
    chk("lit_ovf", {63'd0, overflow}, {63'd0, xo});
  endtask

  initial begin
    logic [63:0] hv_a [3];
    logic [63:0] hv_b [3];
    logic        hv_s [3];
    logic [63:0] hv_r [3];
    logic        hv_c [3];
    int          n;
    int          dcnt;
    bit          got;

    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sum", sum, 64'd0);
    rst = 1'b0;

    run_op(64'h1, 64'h2, 1'b1, 1'b0, 1'b0, 64'h4, 1'b0, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op(64'h5, 64'h7, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_op(64'h1, 64'h2, 1'b1, 1'b0, 1'b1, 64'h4, 1'b0, 1'b0);

    // Abort an add part-way through with an asynchronous reset.
    @(negedge clk);
    a = 64'h1111_1111_1111_1111; b = 64'h2222_2222_2222_2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_run_busy", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_sum", sum, 64'd0);
    chk("abort_cout_ovf", {62'd0, cout, overflow}, 64'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("no_done_after_abort", 64'(dcnt), 64'd0);
    run_op(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0, 1'b0,
           64'h3333_3333_3333_3333, 1'b0, 1'b0);

    // start held high: back-to-back operations, one every N+1 cycles.
    hv_a[0] = 64'h10;        hv_b[0] = 64'h20; hv_s[0] = 1'b0; hv_r[0] = 64'h30;          hv_c[0] = 1'b0;
    hv_a[1] = 64'h100;       hv_b[1] = 64'h1;  hv_s[1] = 1'b1; hv_r[1] = 64'hFF;          hv_c[1] = 1'b1;
    hv_a[2] = 64'hFFFF_FFFF; hv_b[2] = 64'h1;  hv_s[2] = 1'b0; hv_r[2] = 64'h1_0000_0000; hv_c[2] = 1'b0;
    @(negedge clk);
    a = hv_a[0]; b = hv_b[0]; sub = hv_s[0]; cin = 1'b0; start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      n = 0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        n++;
        if (done) got = 1;
      end
      chk("held_spacing", 64'(n), 64'(N + 1));
      chk("held_sum", sum, hv_r[j]);
      chk("held_cout", {63'd0, cout}, {63'd0, hv_c[j]});
      if (j < 2) begin
        a = hv_a[j+1]; b = hv_b[j+1]; sub = hv_s[j+1];
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
